// File: rtl/pipe_stall_ctrl.sv
// Decode-stage stall/flush controller for cache hit/miss and multiply latency.
// Optional performance counters are built only when PIPE_STALL_PERF_EN is defined.
module pipe_stall_ctrl #(
  parameter int unsigned HIT_LAT      = 4,
  parameter int unsigned MULT_LAT     = 32,
  parameter int unsigned MISS_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req_d,
  input  logic        mem_busy,
  input  logic        mem_hit,
  input  logic        mult_start_d,
  input  logic        mult_done,
  input  logic        load_use_stall,
  input  logic        branch_taken_d,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_e,
  output logic        flush_d,
  output logic        mem_timeout,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cycles,
  output logic [15:0] miss_count
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StHitWait  = 2'd1,
    StMissWait = 2'd2,
    StMultWait = 2'd3
  } state_e;

  localparam logic [5:0] HitInit  = 6'(HIT_LAT - 1);
  localparam logic [5:0] MultInit = 6'(MULT_LAT - 1);
  localparam logic [5:0] MissLast = 6'(MISS_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       served_q, served_d;
  logic       timeout_q, timeout_d;
  logic       to_idle;
  logic       req_stall;
  logic       stall;

  // A fresh decode request stalls in the same cycle it is seen.
  assign req_stall = (state_q == StIdle) && !served_q && (mem_req_d || mult_start_d);
  assign stall     = (state_q != StIdle) || load_use_stall || req_stall;

  assign stall_f     = stall;
  assign stall_d     = stall;
  assign flush_e     = stall;
  assign flush_d     = branch_taken_d && !stall;
  assign mem_timeout = timeout_q;
  assign state_o     = state_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    to_idle   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!served_q) begin
          if (mem_req_d) begin
            state_d = StHitWait;
            cnt_d   = HitInit;
          end else if (mult_start_d) begin
            state_d = StMultWait;
            cnt_d   = MultInit;
          end
        end
      end
      StHitWait: begin
        if (mem_busy && !mem_hit) begin
          state_d = StMissWait;
          cnt_d   = 6'd0;
        end else if (cnt_q == 6'd0) begin
          to_idle = 1'b1;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      StMissWait: begin
        if (!mem_busy) begin
          to_idle = 1'b1;
        end else if (cnt_q == MissLast) begin
          timeout_d = 1'b1;
          to_idle   = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StMultWait: begin
        if (mult_done || (cnt_q == 6'd0)) begin
          to_idle = 1'b1;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (to_idle) begin
      state_d = StIdle;
      cnt_d   = 6'd0;
    end
  end

  // served blocks the instruction that was just released from re-triggering.
  always_comb begin
    served_d = served_q;
    if (to_idle) begin
      served_d = 1'b1;
    end else if (!stall) begin
      served_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= 6'd0;
      served_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      served_q  <= served_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] miss_count_q;
  logic        miss_enter;

  assign miss_enter = (state_q == StHitWait) && mem_busy && !mem_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      miss_count_q   <= '0;
    end else begin
      if (stall && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (miss_enter && (miss_count_q != '1)) begin
        miss_count_q <= miss_count_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign miss_count   = miss_count_q;
`else
  assign stall_cycles = '0;
  assign miss_count   = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus random stimulus
// compared each cycle against a hold-budget reference model.
module tb_pipe_stall_ctrl;

  localparam int unsigned HIT_LAT      = 4;
  localparam int unsigned MULT_LAT     = 32;
  localparam int unsigned MISS_TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_d, mem_busy, mem_hit, mult_start_d, mult_done;
  logic        load_use_stall, branch_taken_d;
  logic        stall_f, stall_d, flush_e, flush_d, mem_timeout;
  logic [1:0]  state_o;
  logic [31:0] stall_cycles;
  logic [15:0] miss_count;

  int n_checks = 0;
  int n_errors = 0;
  int stall_seen = 0;

  // Model: kind 0 free, 1 hit hold, 2 miss wait, 3 multiply hold.
  int          m_kind;
  int          m_left;
  int          m_missed;
  bit          m_served;
  bit          m_tmo;
  logic [31:0] m_stalls;
  logic [15:0] m_misses;

  pipe_stall_ctrl #(
    .HIT_LAT     (HIT_LAT),
    .MULT_LAT    (MULT_LAT),
    .MISS_TIMEOUT(MISS_TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req_d     (mem_req_d),
    .mem_busy      (mem_busy),
    .mem_hit       (mem_hit),
    .mult_start_d  (mult_start_d),
    .mult_done     (mult_done),
    .load_use_stall(load_use_stall),
    .branch_taken_d(branch_taken_d),
    .stall_f       (stall_f),
    .stall_d       (stall_d),
    .flush_e       (flush_e),
    .flush_d       (flush_d),
    .mem_timeout   (mem_timeout),
    .state_o       (state_o),
    .stall_cycles  (stall_cycles),
    .miss_count    (miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_stall();
    return (m_kind != 0) || load_use_stall ||
           ((m_kind == 0) && !m_served && (mem_req_d || mult_start_d));
  endfunction

  task automatic model_reset();
    m_kind = 0; m_left = 0; m_missed = 0; m_served = 0; m_tmo = 0;
    m_stalls = '0; m_misses = '0;
  endtask

  task automatic model_step();
    bit s;
    bit done;
    s = model_stall();
    done = 0;
    if (s && (m_stalls != 32'hFFFF_FFFF)) m_stalls++;
    case (m_kind)
      0: begin
        if (!m_served && mem_req_d) begin
          m_kind = 1; m_left = HIT_LAT;
        end else if (!m_served && mult_start_d) begin
          m_kind = 3; m_left = MULT_LAT;
        end
      end
      1: begin
        if (mem_busy && !mem_hit) begin
          m_kind = 2; m_missed = 1;
          if (m_misses != 16'hFFFF) m_misses++;
        end else if (m_left == 1) done = 1;
        else m_left--;
      end
      2: begin
        if (!mem_busy) done = 1;
        else if (m_missed == MISS_TIMEOUT) begin
          m_tmo = 1; done = 1;
        end else m_missed++;
      end
      default: begin
        if (mult_done || (m_left == 1)) done = 1;
        else m_left--;
      end
    endcase
    if (done) begin
      m_kind = 0; m_served = 1;
    end else if (!s) m_served = 0;
  endtask

  task automatic compare_outputs();
    bit s;
    s = model_stall();
    check("stall_f", stall_f, s);
    check("stall_d", stall_d, s);
    check("flush_e", flush_e, s);
    check("flush_d", flush_d, branch_taken_d && !s);
    check("state_o", state_o, m_kind);
    check("mem_timeout", mem_timeout, m_tmo);
`ifdef PIPE_STALL_PERF_EN
    check("stall_cycles", stall_cycles, m_stalls);
    check("miss_count", miss_count, m_misses);
`else
    check("stall_cycles", stall_cycles, 0);
    check("miss_count", miss_count, 0);
`endif
    if (stall_d) stall_seen++;
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    if (reset) model_step();
    #1;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_in(input bit mr, input bit busy, input bit hit, input bit ms,
                        input bit md, input bit lu, input bit bt);
    mem_req_d = mr; mem_busy = busy; mem_hit = hit; mult_start_d = ms;
    mult_done = md; load_use_stall = lu; branch_taken_d = bt;
  endtask

  // Assert reset off-edge, check outputs before any clock, release after a posedge.
  task automatic apply_reset();
    #2 reset = 1'b0;
    model_reset();
    #1;
    compare_outputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    check("rst_stall_d", stall_d, 0);
    check("rst_stall_f", stall_f, 0);
    check("rst_flush_e", flush_e, 0);
    check("rst_flush_d", flush_d, 0);
    check("rst_state", state_o, 0);
    check("rst_timeout", mem_timeout, 0);
    check("rst_stall_cycles", stall_cycles, 0);
    check("rst_miss_count", miss_count, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    hold(2);

    // Cache hit: request cycle plus HIT_LAT held cycles.
    stall_seen = 0;
    set_in(1, 0, 1, 0, 0, 0, 0);
    hold(6);
    check("hit_stall_len", stall_seen, HIT_LAT + 1);
    mem_req_d = 0;
    hold(2);

    // Miss lasting 20 busy cycles.
    set_in(1, 0, 0, 0, 0, 0, 0);
    hold(1);
    mem_busy = 1;
    hold(1);
    check("miss_entered", state_o, 2);
    hold(19);
    mem_busy = 0;
    hold(2);
    mem_req_d = 0;
    hold(2);

    // Miss timeout: flag is sticky.
    set_in(1, 0, 0, 0, 0, 0, 0);
    hold(1);
    mem_busy = 1;
    hold(1);
    mem_req_d = 0;
    hold(MISS_TIMEOUT);
    check("timeout_set", mem_timeout, 1);
    check("timeout_idle", state_o, 0);
    mem_busy = 0;
    hold(3);
    check("timeout_sticky", mem_timeout, 1);

    // Multiply ended by mult_done, then by full latency.
    set_in(0, 0, 0, 1, 0, 0, 0);
    hold(10);
    mult_done = 1;
    hold(1);
    mult_done = 0;
    check("mult_done_exit", state_o, 0);
    hold(1);
    mult_start_d = 0;
    hold(1);
    mult_start_d = 1;
    hold(1 + MULT_LAT);
    check("mult_lat_exit", state_o, 0);
    hold(1);
    mult_start_d = 0;
    hold(1);

    // Simultaneous requests and branch flush gating.
    set_in(1, 0, 1, 1, 0, 0, 0);
    hold(1);
    check("both_hit_first", state_o, 1);
    branch_taken_d = 1;
    hold(HIT_LAT + 1);
    set_in(0, 0, 0, 0, 0, 0, 1);
    hold(1);
    check("flush_d_free", flush_d, 1);
    branch_taken_d = 0;
    hold(1);

    // Asynchronous reset in the middle of a miss.
    set_in(1, 0, 0, 0, 0, 0, 0);
    hold(1);
    mem_busy = 1;
    hold(1);
    mem_req_d = 0;
    hold(15);
    apply_reset();
    check("areset_state", state_o, 0);
    check("areset_timeout", mem_timeout, 0);
    mem_busy = 0;
    hold(2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      mem_req_d      = ($urandom_range(0, 3) == 0);
      mult_start_d   = ($urandom_range(0, 4) == 0);
      mem_hit        = ($urandom_range(0, 1) == 0);
      mult_done      = ($urandom_range(0, 15) == 0);
      load_use_stall = ($urandom_range(0, 7) == 0);
      branch_taken_d = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 11) == 0) mem_busy = ~mem_busy;
      if ($urandom_range(0, 599) == 0) apply_reset();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter HIT_LAT, default 4: cycles decode is held for a cache hit (1..63).
REQ-002 SHALL have parameter MULT_LAT, default 32: maximum cycles held for a multiply (1..63).
REQ-003 SHALL have parameter MISS_TIMEOUT, default 40: maximum cycles held in miss wait (1..63).
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port mem_req_d, input, 1: lw or sw present in decode.
REQ-007 SHALL have port mem_busy, input, 1: cache is fetching or writing a block.
REQ-008 SHALL have port mem_hit, input, 1: cache hit indication (loc_access).
REQ-009 SHALL have port mult_start_d, input, 1: multiply present in decode.
REQ-010 SHALL have port mult_done, input, 1: multiplier result ready.
REQ-011 SHALL have port load_use_stall, input, 1: data-hazard stall request from the hazard unit.
REQ-012 SHALL have port branch_taken_d, input, 1: branch resolved taken in decode.
REQ-013 SHALL have ports stall_f and stall_d, output, 1 each: hold PC and hold the F/D register.
REQ-014 SHALL have ports flush_e and flush_d, output, 1 each: clear the D/E register and clear the F/D register.
REQ-015 SHALL have port mem_timeout, output, 1: sticky miss-timeout error flag.
REQ-016 SHALL have port state_o, output, 2: current FSM state.
REQ-017 SHALL have ports stall_cycles (32) and miss_count (16), outputs: performance counters.

Function
REQ-018 SHALL implement FSM states IDLE=0, HIT_WAIT=1, MISS_WAIT=2, MULT_WAIT=3, plus a 6-bit counter cnt and a served flag.
REQ-019 In IDLE, an unserved request (!served) SHALL trigger a transition: mem_req_d -> HIT_WAIT with cnt=HIT_LAT-1; otherwise mult_start_d -> MULT_WAIT with cnt=MULT_LAT-1.
REQ-020 If mem_req_d and mult_start_d are both high, SHALL give mem_req_d priority.
REQ-021 In HIT_WAIT, mem_busy&&!mem_hit SHALL cause MISS_WAIT with cnt=0; otherwise cnt==0 SHALL cause IDLE; otherwise cnt SHALL decrement.
REQ-022 In MISS_WAIT, mem_busy==0 SHALL cause IDLE; otherwise cnt SHALL increment.
REQ-023 In MISS_WAIT, cnt==MISS_TIMEOUT-1 with mem_busy still high SHALL set mem_timeout and cause IDLE.
REQ-024 In MULT_WAIT, mult_done or cnt==0 SHALL cause IDLE; otherwise cnt SHALL decrement.
REQ-025 Any transition into IDLE SHALL set served=1; served SHALL clear on any cycle with stall_d==0, so the same decode instruction does not re-trigger.
REQ-026 stall_f = stall_d = (state!=IDLE) | load_use_stall | (state==IDLE & !served & (mem_req_d|mult_start_d)); combinational, asserted in the request cycle.
REQ-027 flush_e SHALL equal stall_d, inserting a bubble into execute on every held cycle.
REQ-028 flush_d SHALL equal branch_taken_d & !stall_d.
REQ-029 mem_timeout SHALL be cleared only by reset.
REQ-030 state_o SHALL be a registered copy of the state.

Reset
REQ-031 Asserting reset low SHALL immediately force state=IDLE, cnt=0, served=0, mem_timeout=0, stall_cycles=0, miss_count=0, regardless of the current state.
REQ-032 With reset low and all inputs 0, every output SHALL be 0.
REQ-033 Reset release SHALL take effect at the first rising clk after reset goes high.

Configuration
REQ-034 With macro PIPE_STALL_PERF_EN defined, stall_cycles SHALL increment on every cycle with stall_d=1, saturating at all-ones.
REQ-035 With PIPE_STALL_PERF_EN defined, miss_count SHALL increment on every HIT_WAIT->MISS_WAIT transition, saturating at all-ones.
REQ-036 Without PIPE_STALL_PERF_EN, stall_cycles and miss_count SHALL be constant 0 and no counter flops SHALL be generated.

Verification
REQ-037 HIT_LAT=4; mem_req_d=1, mem_hit=1, mem_busy=0 -> stall_d high for exactly 5 cycles (request plus 4), then low; instruction advances, no re-trigger.
REQ-038 mem_req_d=1, then mem_busy=1 and mem_hit=0 for 20 cycles -> state 1->2; stall held until the cycle after mem_busy falls; miss_count=1 (PERF_EN defined).
REQ-039 MISS_TIMEOUT=40; mem_busy held high indefinitely on a miss -> mem_timeout=1 after 40 MISS_WAIT cycles; state returns to 0; flag persists until reset.
REQ-040 mult_start_d=1, mult_done pulses 10 cycles later -> MULT_WAIT exits on mult_done; stall_d low on the following cycle; mult_done absent -> exit after 32 cycles.
REQ-041 mem_req_d and mult_start_d both high -> HIT_WAIT entered; branch_taken_d=1 while stalled -> flush_d=0; branch_taken_d=1 with no stall -> flush_d=1.
REQ-042 reset driven low mid MISS_WAIT (cnt=15) -> state_o=0, stall_d=0, and counters 0 without waiting for a clock edge.
